// File: rtl/fec2d_dec_pipe.sv
// Two-stage streaming 2D-parity FEC decoder: S1 captures data and syndromes, S2 holds the
// classified and optionally corrected word. One word per cycle with valid/ready on both sides.
module fec2d_dec_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*DEPTH-1:0]   in_data,
  input  logic [DEPTH-1:0]         in_row_par,
  input  logic [WIDTH-1:0]         in_col_par,
  input  logic                     in_tot_par,
  input  logic                     correct_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*DEPTH-1:0]   out_data,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH)-1:0] out_err_row,
  output logic [$clog2(WIDTH)-1:0] out_err_col,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         cnt_corr,
  output logic [CNT_W-1:0]         cnt_uncorr
);

  localparam int unsigned N  = WIDTH * DEPTH;
  localparam int unsigned RW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StClean      = 2'd0,
    StCorrected  = 2'd1,
    StParityOnly = 2'd2,
    StUncorr     = 2'd3
  } status_e;

  // Holds in_ready low until the first clock edge after reset is released.
  logic init_q;

  logic             s1_valid_q;
  logic [N-1:0]     s1_data_q;
  logic [DEPTH-1:0] s1_rs_q;
  logic [WIDTH-1:0] s1_cs_q;
  logic             s1_ts_q;
  logic             s1_ce_q;

  logic             s2_valid_q;
  logic [N-1:0]     s2_data_q;
  status_e          s2_status_q;
  logic [RW-1:0]    s2_row_q;
  logic [CW-1:0]    s2_col_q;

  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  logic [DEPTH-1:0] calc_row;
  logic [WIDTH-1:0] calc_col;
  logic             calc_tot;

  logic [N-1:0]     s2_data_d;
  status_e          s2_status_d;
  logic [RW-1:0]    s2_row_d;
  logic [CW-1:0]    s2_col_d;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = init_q && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    calc_row = '0;
    calc_col = '0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      for (int c = 0; c < int'(WIDTH); c++) begin
        calc_row[r] = calc_row[r] ^ in_data[r*WIDTH+c];
        calc_col[c] = calc_col[c] ^ in_data[r*WIDTH+c];
      end
    end
    calc_tot = ^in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_rs_q    <= '0;
      s1_cs_q    <= '0;
      s1_ts_q    <= 1'b0;
      s1_ce_q    <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (init_q && (!s1_valid_q || s1_adv)) begin
        s1_valid_q <= in_valid;
      end
      if (in_fire) begin
        s1_data_q <= in_data;
        s1_rs_q   <= in_row_par ^ calc_row;
        s1_cs_q   <= in_col_par ^ calc_col;
        s1_ts_q   <= in_tot_par ^ calc_tot;
        s1_ce_q   <= correct_en;
      end
    end
  end

  // With one-hot row and column syndromes the flip mask has exactly one bit set.
  always_comb begin
    logic [N-1:0]  flip_mask;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    flip_mask   = '0;
    row_idx     = '0;
    col_idx     = '0;
    s2_data_d   = s1_data_q;
    s2_status_d = StUncorr;
    s2_row_d    = '0;
    s2_col_d    = '0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      for (int c = 0; c < int'(WIDTH); c++) begin
        flip_mask[r*WIDTH+c] = s1_rs_q[r] & s1_cs_q[c];
      end
      if (s1_rs_q[r]) row_idx = RW'(r);
    end
    for (int c = 0; c < int'(WIDTH); c++) begin
      if (s1_cs_q[c]) col_idx = CW'(c);
    end

    if (s1_rs_q == '0 && s1_cs_q == '0 && !s1_ts_q) begin
      s2_status_d = StClean;
    end else if ($onehot(s1_rs_q) && $onehot(s1_cs_q) && s1_ts_q) begin
      if (s1_ce_q) begin
        s2_data_d   = s1_data_q ^ flip_mask;
        s2_status_d = StCorrected;
        s2_row_d    = row_idx;
        s2_col_d    = col_idx;
      end
    end else if ($onehot({s1_rs_q, s1_cs_q, s1_ts_q})) begin
      s2_status_d = StParityOnly;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_status_q <= StClean;
      s2_row_q    <= '0;
      s2_col_q    <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q   <= s2_data_d;
        s2_status_q <= s2_status_d;
        s2_row_q    <= s2_row_d;
        s2_col_q    <= s2_col_d;
      end
    end
  end

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_fire) begin
      if ((s2_status_q == StCorrected || s2_status_q == StParityOnly) && cnt_corr_q != '1) begin
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      end
      if (s2_status_q == StUncorr && cnt_uncorr_q != '1) begin
        cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_status  = s2_status_q;
  assign out_err_row = s2_row_q;
  assign out_err_col = s2_col_q;
  assign cnt_corr    = cnt_corr_q;
  assign cnt_uncorr  = cnt_uncorr_q;

endmodule

// File: tb/tb_fec2d_dec_pipe.sv
// Scoreboard bench for fec2d_dec_pipe at 4x4 with 2-bit counters: directed words push expected
// results; a negedge monitor pops and compares on every output handshake.
module tb_fec2d_dec_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  st;
    logic [1:0]  r;
    logic [1:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_row_par;
  logic [3:0]  in_col_par;
  logic        in_tot_par;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_status;
  logic [1:0]  out_err_row;
  logic [1:0]  out_err_col;
  logic        clr_cnt;
  logic [1:0]  cnt_corr;
  logic [1:0]  cnt_uncorr;

  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  exp_t exp_q[$];

  fec2d_dec_pipe #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_row_par  (in_row_par),
    .in_col_par  (in_col_par),
    .in_tot_par  (in_tot_par),
    .correct_en  (correct_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_status  (out_status),
    .out_err_row (out_err_row),
    .out_err_col (out_err_col),
    .clr_cnt     (clr_cnt),
    .cnt_corr    (cnt_corr),
    .cnt_uncorr  (cnt_uncorr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one word from posedge+1, waits for acceptance, then drops in_valid.
  task automatic send(input logic [15:0] d, input logic [3:0] rp, input logic [3:0] cp,
                      input logic tp, input logic ce, input exp_t e);
    int n = 0;
    in_data    = d;
    in_row_par = rp;
    in_col_par = cp;
    in_tot_par = tp;
    correct_en = ce;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      accepted++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, plus output stability while stalled.
  initial begin
    logic        stall_prev;
    logic [21:0] snap;
    exp_t        e;
    stall_prev = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (out_valid && stall_prev) begin
          chk("stable under stall", 32'({out_data, out_status, out_err_row, out_err_col}),
              32'(snap));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out word {data,st,row,col}",
                32'({out_data, out_status, out_err_row, out_err_col}), 32'(e));
          end
        end
        stall_prev = out_valid && !out_ready;
        snap       = {out_data, out_status, out_err_row, out_err_col};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int fires;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_row_par = '0;
    in_col_par = '0;
    in_tot_par = 1'b0;
    correct_en = 1'b1;
    out_ready  = 1'b1;
    clr_cnt    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset status", 32'(out_status), 32'd0);
    chk("reset counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    // Clean word and two-cycle latency.
    send(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd0, 2'd0, 2'd0});
    @(negedge clk);
    chk("latency: not valid after 1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency: valid after 2", 32'(out_valid), 32'd1);
    drain();
    chk("clean counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);

    send(16'h0200, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd1, 2'd2, 2'd1});
    drain();
    chk("cnt_corr after correction", 32'(cnt_corr), 32'd1);

    send(16'h0200, 4'b0000, 4'b0000, 1'b0, 1'b0, '{16'h0200, 2'd3, 2'd0, 2'd0});
    drain();
    chk("cnt_uncorr detect-only", 32'(cnt_uncorr), 32'd1);

    send(16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd2, 2'd0, 2'd0});
    drain();
    chk("cnt_corr parity-only", 32'(cnt_corr), 32'd2);

    send(16'h0003, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0003, 2'd3, 2'd0, 2'd0});
    drain();
    chk("cnt_uncorr double", 32'(cnt_uncorr), 32'd2);

    // clr_cnt coinciding with a corrected-word handshake: clear wins.
    out_ready = 1'b0;
    send(16'h0200, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd1, 2'd2, 2'd1});
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("held word present", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr wins over increment", 32'({cnt_corr, cnt_uncorr}), 32'd0);

    // Backpressure: five single-error words on a background whose parities are all zero.
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        send(16'hA5C2, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'hA5C3, 2'd1, 2'd0, 2'd0});
        send(16'hA583, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'hA5C3, 2'd1, 2'd1, 2'd2});
        send(16'h25C3, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'hA5C3, 2'd1, 2'd3, 2'd3});
        send(16'hA4C3, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'hA5C3, 2'd1, 2'd2, 2'd0});
        send(16'hA5CB, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'hA5C3, 2'd1, 2'd0, 2'd3});
      end
      begin
        repeat (2) @(negedge clk);
        repeat (4) begin
          @(negedge clk);
          chk("in_ready low while stalled", 32'(in_ready), 32'd0);
        end
        chk("words accepted while stalled", 32'(accepted), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fires = 0;
        repeat (5) begin
          @(negedge clk);
          if (out_valid && out_ready) fires++;
        end
        chk("one delivery per cycle", 32'(fires), 32'd5);
      end
    join
    drain();
    chk("cnt_corr saturates", 32'(cnt_corr), 32'd3);
    chk("cnt_uncorr unchanged", 32'(cnt_uncorr), 32'd0);

    // Reset while a word is held at the output.
    out_ready = 1'b0;
    send(16'h0200, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd1, 2'd2, 2'd1});
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("word held before reset", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("out_valid drops on reset", 32'(out_valid), 32'd0);
    chk("counters clear on reset", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after mid reset", 32'(in_ready), 32'd1);
    send(16'h0008, 4'b0000, 4'b0000, 1'b0, 1'b1, '{16'h0000, 2'd1, 2'd0, 2'd3});
    drain();
    chk("cnt_corr after reset", 32'(cnt_corr), 32'd1);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fec2d_dec_pipe.md
Name: fec2d_dec_pipe

Overview:
- Pipelined, streaming 2D-parity FEC decoder for a WIDTH x DEPTH data block, with an overall parity bit.
- Classifies every word: clean, single data-bit error (corrected), parity-only error, or uncorrectable.
- Valid/ready handshakes on input and output; full throughput of one word per cycle.
- Sits between the link receiver and the consumer. Replaces the iterative FSM decoder for high-rate paths.

Parameters:
- WIDTH, 8, data bits per row (columns); >= 2
- DEPTH, 8, rows per block; >= 2
- CNT_W, 16, width of the saturating error counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept a word
- in_data  in  WIDTH*DEPTH  data block; row r = in_data[r*WIDTH +: WIDTH], column c = bit c of each row
- in_row_par  in  DEPTH  received row parity, bit r = XOR of row r
- in_col_par  in  WIDTH  received column parity, bit c = XOR of column c
- in_tot_par  in  1  received overall parity = XOR of all data bits
- correct_en  in  1  1 = correct single data errors; 0 = detect only
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  WIDTH*DEPTH  corrected or passed-through data
- out_status  out  2  0 CLEAN, 1 CORRECTED, 2 PARITY_ONLY, 3 UNCORRECTABLE
- out_err_row  out  clog2(DEPTH)  row of the corrected bit; 0 unless status is 1
- out_err_col  out  clog2(WIDTH)  column of the corrected bit; 0 unless status is 1
- clr_cnt  in  1  synchronous counter clear
- cnt_corr  out  CNT_W  count of delivered words with status 1 or 2
- cnt_uncorr  out  CNT_W  count of delivered words with status 3

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values: every output register, both valid flags and both counters are 0. in_ready is 1 one cycle after rst deasserts.
- Syndromes: rs = in_row_par ^ calc_row, cs = in_col_par ^ calc_col, ts = in_tot_par ^ calc_tot.
- Classification, evaluated in priority order:
  - rs==0, cs==0, ts==0 -> CLEAN.
  - rs one-hot, cs one-hot, ts==1 -> single data-bit error at (r,c).
    - correct_en=1: flip bit (r,c), status CORRECTED, err_row/err_col = r/c.
    - correct_en=0: data unmodified, status UNCORRECTABLE.
  - Exactly one set bit across {rs, cs, ts} -> PARITY_ONLY, data unmodified.
  - Any other case -> UNCORRECTABLE, data unmodified.
- Pipeline:
  - S1 registers data, syndromes and correct_en on the input handshake (in_valid && in_ready).
  - S2 registers the corrected data, status and location.
  - Latency is 2 cycles from input handshake to out_valid when no backpressure is applied.
- Flow control:
  - S1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || (S1 advances). This is combinational from out_ready; there is no combinational path from in_valid.
  - While out_valid && !out_ready, all out_* signals are held stable.
  - Words are never dropped, duplicated or reordered.
  - Simultaneous S2 drain and S1 refill in one cycle is supported.
- correct_en is sampled at input acceptance and travels with the word. Changing it mid-stream affects only later words.
- Counters:
  - Update on the output handshake (out_valid && out_ready).
  - Saturate at all-ones with no wrap.
  - clr_cnt zeroes both counters. clr_cnt wins over a simultaneous increment.
- Reset mid-operation: in-flight words are discarded, out_valid drops immediately, and counters clear.

Test Plan (WIDTH=DEPTH=4, CNT_W=2 unless noted):
- Clean word: in_data=16'h0000, all parity inputs 0, out_ready=1.
  -> out_valid high 2 cycles after accept; out_data=16'h0000, status 0; counters stay 0.
- Single data error (row 2, col 1): in_data=16'h0200, parities 0, correct_en=1.
  -> out_data=16'h0000, status 1, err_row=2, err_col=1, cnt_corr=1.
- Same word with correct_en=0.
  -> out_data=16'h0200, status 3, cnt_uncorr=1.
- Parity-only error: in_data=0, in_row_par=4'b0100. -> out_data=0, status 2.
- Double error: in_data=16'h0003, parities 0 (rs=0, cs=4'b0011, ts=0). -> out_data=16'h0003, status 3.
- Backpressure and saturation:
  - Stimulus: push 5 single-error words back-to-back with out_ready=0 for 6 cycles.
  - While stalled: exactly 2 words are accepted, in_ready stays 0, and outputs are stable.
  - After release: the 5 words are delivered in order, one per cycle, and cnt_corr saturates at 3.
  - Asserting rst mid-stream drops out_valid to 0 immediately.
